cla_sub16_serial: RTL and testbench

//  Digit-serial subtractor, the inverse of the 16-bit carry-lookahead adder: computes D = A - B - Bin.

---
 rtl/cla_sub16_serial.sv | 128 ++++++++++++
 tb/tb_cla_sub16_serial.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cla_sub16_serial.sv
// Digit-serial subtractor D = A - B - Bin, one SLICE-bit digit per clock with in-slice borrow lookahead.
// Optional build macro SUB_SAT_EN: unsigned saturating result (D forced to 0 on final borrow).
//
// state | meaning
// IDLE  | waiting for start, no result held
// RUN   | resolving one slice per clock, busy=1
// DONE  | result held, valid=1, start accepted back-to-back
module cla_sub16_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             ZERO
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] sg;
   logic [SLICE-1:0] sp;
   logic [SLICE-1:0] sd;
   logic [SLICE:0]   sbr;
   logic             slice_bout;
   logic [WIDTH-1:0] d_next;

   // Borrow into bit j is a flat OR of (generate at k, or borrow-in) AND all propagates above it.
   always_comb begin
      logic acc;
      logic prod;
      acc  = 1'b0;
      prod = 1'b0;
      sa   = a_r[cnt*SLICE +: SLICE];
      sb   = b_r[cnt*SLICE +: SLICE];
      sg   = ~sa & sb;
      sp   = ~(sa ^ sb);
      sbr  = '0;
      sbr[0] = brw;
      for (int j = 1; j <= SLICE; j++) begin
         acc = 1'b0;
         for (int k = 0; k <= j; k++) begin
            prod = (k == 0) ? brw : sg[k-1];
            for (int m = k; m < j; m++) begin
               prod = prod & sp[m];
            end
            acc = acc | prod;
         end
         sbr[j] = acc;
      end
      sd         = sa ^ sb ^ sbr[SLICE-1:0];
      slice_bout = sbr[SLICE];
      d_next     = D;
      d_next[cnt*SLICE +: SLICE] = sd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         valid <= 1'b0;
         D     <= '0;
         Bout  <= 1'b0;
         ZERO  <= 1'b0;
         cnt   <= '0;
         brw   <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  valid <= 1'b0;
                  a_r   <= A;
                  b_r   <= B;
                  brw   <= Bin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               D   <= d_next;
               brw <= slice_bout;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
                  Bout  <= slice_bout;
                  ZERO  <= (d_next == '0);
`ifdef SUB_SAT_EN
                  if (slice_bout) begin
                     D    <= '0;
                     ZERO <= 1'b1;
                  end
`else
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_sub16_serial.sv
// Bench for cla_sub16_serial: directed cases plus random operands against an arithmetic model.
// Honours SUB_SAT_EN the same way as the design when computing expected results.
module tb_cla_sub16_serial;

   localparam int W  = 16;
   localparam int NS = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         valid;
   logic [W-1:0] d;
   logic         bout;
   logic         zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cla_sub16_serial #(.WIDTH(W), .SLICE(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (a),
      .B     (b),
      .Bin   (bin),
      .busy  (busy),
      .valid (valid),
      .D     (d),
      .Bout  (bout),
      .ZERO  (zero)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; issues one op and returns at the negedge where valid should rise.
   task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input bit poke);
      logic [W:0]   full;
      logic [W-1:0] ed;
      logic         eb;
      logic         ez;
      full = {1'b0, oa} - {1'b0, ob} - (W+1)'(obin);
      ed   = full[W-1:0];
      eb   = full[W];
`ifdef SUB_SAT_EN
      if (eb) ed = '0;
`else
`endif
      ez    = (ed == '0);
      a     = oa;
      b     = ob;
      bin   = obin;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = poke;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      chk("busy_after_accept", busy, 1);
      chk("valid_after_accept", valid, 0);
      for (int i = 1; i <= NS; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i < NS) begin
            chk("valid_low_run", valid, 0);
            chk("busy_high_run", busy, 1);
         end
      end
      chk("valid_done", valid, 1);
      chk("busy_done", busy, 0);
      chk("d", d, ed);
      chk("bout", bout, eb);
      chk("zero", zero, ez);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_d", d, 0);
      chk("rst_bout", bout, 0);
      chk("rst_zero", zero, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_valid", valid, 0);

      do_op(16'h1234, 16'h0234, 1'b0, 1'b0);
      do_op(16'h0000, 16'h0001, 1'b0, 1'b0);
      do_op(16'hABCD, 16'hABCD, 1'b0, 1'b0);
      do_op(16'hABCD, 16'hABCD, 1'b1, 1'b0);
      do_op(16'h5555, 16'h1111, 1'b0, 1'b1);

      repeat (5) @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_d", d, 16'h4444);
      chk("hold_bout", bout, 0);

      a     = 16'h0F0F;
      b     = 16'h0001;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", valid, 0);
      chk("abort_d", d, 0);
      chk("abort_bout", bout, 0);
      chk("abort_zero", zero, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b0);

      do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
      do_op(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      do_op(16'h0000, 16'hFFFF, 1'b0, 1'b0);

      for (int n = 0; n < 5000; n++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
